// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared definitions for the AXI4-Lite N:1 arbiter: bus widths, response codes and
// the arbitration state type used by both the write and read FSMs.
package axi4_lite_Defs;

    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The read FSM reuses RESP as its data-return phase.
    typedef enum logic [1:0] {IDLE, ADDR, RESP} arb_state_t;

endpackage

// File: rtl/axi4_lite_arbiter_rr.sv
// Combinational round-robin picker: returns the first requester at or after ptr,
// wrapping around modulo N.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    // Rotate so bit 0 is the pointer's master, find the lowest set bit, then un-rotate.
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N-1:0];
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) offset = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
        gnt_idx = sum[IDX_W-1:0];
        any     = |req;
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite slave between N_MST masters; write and read paths each have
// their own round-robin arbiter and FSM, and a grant is held until the response handshake.
module axi4_lite_arbiter
    import axi4_lite_Defs::*;
#(
    parameter int N_MST  = 2,
    parameter int ADDR_W = Addr_Width,
    parameter int DATA_W = Data_Width
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [N_MST*ADDR_W-1:0]     m_awaddr,
    input  logic [N_MST-1:0]            m_awvalid,
    output logic [N_MST-1:0]            m_awready,
    input  logic [N_MST*DATA_W-1:0]     m_wdata,
    input  logic [N_MST*DATA_W/8-1:0]   m_wstrb,
    input  logic [N_MST-1:0]            m_wvalid,
    output logic [N_MST-1:0]            m_wready,
    output logic [1:0]                  m_bresp,
    output logic [N_MST-1:0]            m_bvalid,
    input  logic [N_MST-1:0]            m_bready,
    input  logic [N_MST*ADDR_W-1:0]     m_araddr,
    input  logic [N_MST-1:0]            m_arvalid,
    output logic [N_MST-1:0]            m_arready,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [1:0]                  m_rresp,
    output logic [N_MST-1:0]            m_rvalid,
    input  logic [N_MST-1:0]            m_rready,
    output logic [ADDR_W-1:0]           s_awaddr,
    output logic                        s_awvalid,
    input  logic                        s_awready,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [DATA_W/8-1:0]         s_wstrb,
    output logic                        s_wvalid,
    input  logic                        s_wready,
    input  logic [1:0]                  s_bresp,
    input  logic                        s_bvalid,
    output logic                        s_bready,
    output logic [ADDR_W-1:0]           s_araddr,
    output logic                        s_arvalid,
    input  logic                        s_arready,
    input  logic [DATA_W-1:0]           s_rdata,
    input  logic [1:0]                  s_rresp,
    input  logic                        s_rvalid,
    output logic                        s_rready,
    output logic [$clog2(N_MST)-1:0]    wr_gnt,
    output logic [$clog2(N_MST)-1:0]    rd_gnt
);

    localparam int IDX_W = $clog2(N_MST);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_MST - 1);

    arb_state_t       wr_state, wr_state_next, rd_state, rd_state_next;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_next, wr_gnt_next, wr_arb_idx;
    logic [IDX_W-1:0] rd_ptr, rd_ptr_next, rd_gnt_next, rd_arb_idx;
    logic             aw_done, aw_done_next, w_done, w_done_next;
    logic             wr_any, rd_any;

    rr_arbiter #(.N(N_MST)) u_wr_arb (.req(m_awvalid), .ptr(wr_ptr), .gnt_idx(wr_arb_idx), .any(wr_any));
    rr_arbiter #(.N(N_MST)) u_rd_arb (.req(m_arvalid), .ptr(rd_ptr), .gnt_idx(rd_arb_idx), .any(rd_any));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= IDLE;
            wr_gnt   <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rd_state <= IDLE;
            rd_gnt   <= '0;
            rd_ptr   <= '0;
        end else begin
            wr_state <= wr_state_next;
            wr_gnt   <= wr_gnt_next;
            wr_ptr   <= wr_ptr_next;
            aw_done  <= aw_done_next;
            w_done   <= w_done_next;
            rd_state <= rd_state_next;
            rd_gnt   <= rd_gnt_next;
            rd_ptr   <= rd_ptr_next;
        end
    end

    // Payload muxes depend only on the registered grants.
    always_comb begin
        s_awaddr = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        s_araddr = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (wr_gnt == IDX_W'(i)) begin
                s_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
                s_wdata  = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb  = m_wstrb[i*(DATA_W/8) +: (DATA_W/8)];
            end
            if (rd_gnt == IDX_W'(i)) s_araddr = m_araddr[i*ADDR_W +: ADDR_W];
        end
    end

    assign m_bresp = s_bresp;
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;

    // Write FSM: done flags stop a second AW or W transfer reaching the slave.
    always_comb begin
        wr_state_next = wr_state;
        wr_gnt_next   = wr_gnt;
        wr_ptr_next   = wr_ptr;
        aw_done_next  = aw_done;
        w_done_next   = w_done;
        s_awvalid     = 1'b0;
        s_wvalid      = 1'b0;
        s_bready      = 1'b0;
        m_awready     = '0;
        m_wready      = '0;
        m_bvalid      = '0;
        case (wr_state)
            IDLE: begin
                if (wr_any) begin
                    wr_gnt_next   = wr_arb_idx;
                    wr_state_next = ADDR;
                end
            end
            ADDR: begin
                s_awvalid         = m_awvalid[wr_gnt] & ~aw_done;
                s_wvalid          = m_wvalid[wr_gnt] & ~w_done;
                m_awready[wr_gnt] = s_awready & ~aw_done;
                m_wready[wr_gnt]  = s_wready & ~w_done;
                aw_done_next      = aw_done | (s_awvalid & s_awready);
                w_done_next       = w_done | (s_wvalid & s_wready);
                if (aw_done_next && w_done_next) begin
                    aw_done_next  = 1'b0;
                    w_done_next   = 1'b0;
                    wr_state_next = RESP;
                end
            end
            RESP: begin
                m_bvalid[wr_gnt] = s_bvalid;
                s_bready         = m_bready[wr_gnt];
                if (s_bvalid && s_bready) begin
                    wr_ptr_next   = (wr_gnt == LAST) ? '0 : wr_gnt + IDX_W'(1);
                    wr_state_next = IDLE;
                end
            end
            default: wr_state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_gnt_next   = rd_gnt;
        rd_ptr_next   = rd_ptr;
        s_arvalid     = 1'b0;
        s_rready      = 1'b0;
        m_arready     = '0;
        m_rvalid      = '0;
        case (rd_state)
            IDLE: begin
                if (rd_any) begin
                    rd_gnt_next   = rd_arb_idx;
                    rd_state_next = ADDR;
                end
            end
            ADDR: begin
                s_arvalid         = m_arvalid[rd_gnt];
                m_arready[rd_gnt] = s_arready;
                if (s_arvalid && s_arready) rd_state_next = RESP;
            end
            RESP: begin
                m_rvalid[rd_gnt] = s_rvalid;
                s_rready         = m_rready[rd_gnt];
                if (s_rvalid && s_rready) begin
                    rd_ptr_next   = (rd_gnt == LAST) ? '0 : rd_gnt + IDX_W'(1);
                    rd_state_next = IDLE;
                end
            end
            default: rd_state_next = IDLE;
        endcase
    end

    // A granted master must keep its address VALID until the handshake.
    aw_hold_a: assert property (@(posedge ACLK) disable iff (ARESET)
        (wr_state == ADDR && !aw_done) |-> m_awvalid[wr_gnt]);
    ar_hold_a: assert property (@(posedge ACLK) disable iff (ARESET)
        (rd_state == ADDR) |-> m_arvalid[rd_gnt]);

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter with two masters; the bench plays both the masters
// and the slave, and a scoreboard queue holds each expected transaction in service order.
module tb_axi4_lite_arbiter;
    import axi4_lite_Defs::*;

    localparam int N = 2;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [63:0] m_awaddr = '0, m_araddr = '0, m_wdata = '0;
    logic [7:0]  m_wstrb = '0;
    logic [1:0]  m_awvalid = '0, m_wvalid = '0, m_bready = '0, m_arvalid = '0, m_rready = '0;
    logic [1:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_bresp, m_rresp;
    logic [31:0] m_rdata, s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic        s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0, s_arready = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = '0, s_rresp = '0;
    logic [31:0] s_rdata = '0;
    logic        wr_gnt, rd_gnt;

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } txn_t;

    txn_t wq[$];
    txn_t rq[$];
    int checks = 0;
    int errors = 0;

    axi4_lite_arbiter #(.N_MST(N), .ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput(tag, {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                          m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 64'd0);
    endtask

    function automatic logic [1:0] oneHot(input int m);
        logic [1:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    task automatic applyWriteStimulus(input int mst, input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, input logic [1:0] resp);
        txn_t t;
        m_awaddr[mst*32 +: 32] = addr;
        m_wdata[mst*32 +: 32]  = data;
        m_wstrb[mst*4 +: 4]    = strb;
        m_awvalid[mst]         = 1'b1;
        m_wvalid[mst]          = 1'b1;
        t = '{mst, addr, data, strb, resp};
        wq.push_back(t);
    endtask

    task automatic applyReadStimulus(input int mst, input logic [31:0] addr, input logic [31:0] data,
                                     input logic [1:0] resp);
        txn_t t;
        m_araddr[mst*32 +: 32] = addr;
        m_arvalid[mst]         = 1'b1;
        t = '{mst, addr, data, 4'h0, resp};
        rq.push_back(t);
    endtask

    // Grant edge, address phase with slave ready latencies, then B with b_hold cycles of backpressure.
    task automatic serveWrite(input int aw_lat, input int w_lat, input int b_hold, input bit hold_w);
        txn_t t;
        int cyc, aw_hs, w_hs;
        bit aw_ok, w_ok;
        logic [1:0] oh;
        tick;
        if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL write_queue_empty observed=0 expected=1");
            return;
        end
        t = wq.pop_front();
        oh = oneHot(t.mst);
        checkOutput("wr_gnt", wr_gnt, t.mst);
        checkOutput("s_awaddr", s_awaddr, t.addr);
        checkOutput("s_wdata", s_wdata, t.data);
        checkOutput("s_wstrb", s_wstrb, t.strb);
        cyc = 0; aw_hs = 0; w_hs = 0; aw_ok = 0; w_ok = 0;
        while (!(aw_ok && w_ok) && cyc < 10) begin
            s_awready = (cyc >= aw_lat);
            s_wready  = (cyc >= w_lat);
            #1;
            checkOutput("s_awvalid", s_awvalid, !aw_ok);
            checkOutput("s_wvalid", s_wvalid, !w_ok);
            checkOutput("m_awready", m_awready, (!aw_ok && cyc >= aw_lat) ? oh : 2'b00);
            checkOutput("m_wready", m_wready, (!w_ok && cyc >= w_lat) ? oh : 2'b00);
            if (s_awvalid && s_awready) aw_hs++;
            if (s_wvalid && s_wready) w_hs++;
            if (cyc >= aw_lat) aw_ok = 1;
            if (cyc >= w_lat) w_ok = 1;
            tick;
            if (aw_ok) m_awvalid[t.mst] = 1'b0;
            if (w_ok && !hold_w) m_wvalid[t.mst] = 1'b0;
            cyc++;
        end
        s_awready = 1'b0;
        s_wready  = 1'b0;
        m_wvalid[t.mst] = 1'b0;
        checkOutput("aw_handshakes", aw_hs, 1);
        checkOutput("w_handshakes", w_hs, 1);
        checkOutput("addr_cycles", cyc, ((aw_lat > w_lat) ? aw_lat : w_lat) + 1);
        s_bvalid = 1'b1;
        s_bresp  = t.resp;
        for (int k = 0; k < b_hold; k++) begin
            #1;
            checkOutput("m_bvalid_wait", m_bvalid, oh);
            checkOutput("s_bready_wait", s_bready, 0);
            tick;
        end
        m_bready[t.mst] = 1'b1;
        #1;
        checkOutput("m_bvalid", m_bvalid, oh);
        checkOutput("m_bresp", m_bresp, t.resp);
        checkOutput("s_bready", s_bready, 1);
        checkOutput("s_awvalid_resp", s_awvalid, 0);
        tick;
        s_bvalid = 1'b0;
        s_bresp  = '0;
        m_bready[t.mst] = 1'b0;
        #1;
        checkOutput("m_bvalid_idle", m_bvalid, 0);
    endtask

    // Grant edge, AR handshake, then R with r_hold cycles of master backpressure;
    // optionally another master raises a read while this one is still in its data phase.
    task automatic serveRead(input int r_hold, input int inj_mst, input logic [31:0] inj_addr,
                             input logic [31:0] inj_data);
        txn_t t;
        logic [1:0] oh;
        tick;
        if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL read_queue_empty observed=0 expected=1");
            return;
        end
        t = rq.pop_front();
        oh = oneHot(t.mst);
        checkOutput("rd_gnt", rd_gnt, t.mst);
        checkOutput("s_araddr", s_araddr, t.addr);
        checkOutput("s_arvalid", s_arvalid, 1);
        s_arready = 1'b1;
        #1;
        checkOutput("m_arready", m_arready, oh);
        tick;
        m_arvalid[t.mst] = 1'b0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = t.data;
        s_rresp   = t.resp;
        for (int k = 0; k < r_hold; k++) begin
            if (k == 1 && inj_mst >= 0) applyReadStimulus(inj_mst, inj_addr, inj_data, RESP_OKAY);
            #1;
            checkOutput("m_rvalid_wait", m_rvalid, oh);
            checkOutput("s_rready_wait", s_rready, 0);
            checkOutput("rd_gnt_wait", rd_gnt, t.mst);
            checkOutput("s_arvalid_wait", s_arvalid, 0);
            tick;
        end
        m_rready[t.mst] = 1'b1;
        #1;
        checkOutput("m_rvalid", m_rvalid, oh);
        checkOutput("m_rdata", m_rdata, t.data);
        checkOutput("m_rresp", m_rresp, t.resp);
        checkOutput("s_rready", s_rready, 1);
        tick;
        s_rvalid = 1'b0;
        m_rready[t.mst] = 1'b0;
        #1;
        checkOutput("m_rvalid_idle", m_rvalid, 0);
    endtask

    initial begin
        $display("[TB] start");
        tick;
        tick;
        checkQuiet("reset_quiet");
        checkOutput("reset_wr_gnt", wr_gnt, 0);
        checkOutput("reset_rd_gnt", rd_gnt, 0);
        ARESET = 1'b0;
        tick;

        // Single write from master 1; nothing reaches the slave while still idle.
        applyWriteStimulus(1, 32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY);
        #1;
        checkOutput("idle_no_comb_path", s_awvalid, 0);
        serveWrite(0, 0, 0, 0);

        // Reset in the middle of a write (W already accepted) and a read.
        m_awaddr[32 +: 32] = 32'h50;
        m_awvalid[1] = 1'b1;
        m_wvalid[1]  = 1'b1;
        m_araddr[32 +: 32] = 32'h60;
        m_arvalid[1] = 1'b1;
        tick;
        checkOutput("midburst_wr_gnt", wr_gnt, 1);
        checkOutput("midburst_rd_gnt", rd_gnt, 1);
        checkOutput("midburst_s_awvalid", s_awvalid, 1);
        s_wready = 1'b1;
        tick;
        s_wready  = 1'b0;
        s_awready = 1'b1;
        s_arready = 1'b1;
        s_bvalid  = 1'b1;
        s_rvalid  = 1'b1;
        ARESET    = 1'b1;
        #1;
        checkQuiet("midburst_reset_quiet");
        checkOutput("midburst_reset_wr_gnt", wr_gnt, 0);
        checkOutput("midburst_reset_rd_gnt", rd_gnt, 0);
        m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
        s_awready = 1'b0; s_arready = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
        tick;
        ARESET = 1'b0;
        tick;

        // Contention from reset: M0 then M1, again M0 then M1, then rotation puts M1 ahead.
        applyWriteStimulus(0, 32'h100, 32'h00000A0A, 4'h3, RESP_OKAY);
        applyWriteStimulus(1, 32'h104, 32'h00000B0B, 4'hC, RESP_OKAY);
        serveWrite(0, 2, 0, 0);
        serveWrite(1, 0, 2, 0);
        applyWriteStimulus(0, 32'h200, 32'h11112222, 4'hF, RESP_OKAY);
        applyWriteStimulus(1, 32'h204, 32'h33334444, 4'hF, RESP_SLVERR);
        serveWrite(0, 0, 0, 0);
        applyWriteStimulus(0, 32'h208, 32'h55556666, 4'h1, RESP_OKAY);
        serveWrite(0, 0, 0, 0);
        serveWrite(0, 0, 0, 0);

        // W accepted three cycles ahead of AW while the master keeps offering W.
        applyWriteStimulus(1, 32'h300, 32'h0BADF00D, 4'hF, RESP_OKAY);
        serveWrite(3, 0, 0, 1);

        // Read by M0 and write by M1 in parallel.
        applyReadStimulus(0, 32'h20, 32'hCAFEF00D, RESP_OKAY);
        applyWriteStimulus(1, 32'h30, 32'h12345678, 4'hF, RESP_SLVERR);
        fork
            serveWrite(0, 1, 1, 0);
            serveRead(0, -1, 32'h0, 32'h0);
        join

        // M0 stalls its R channel; M1's read waits for the R handshake.
        applyReadStimulus(0, 32'h400, 32'hA5A5A5A5, RESP_SLVERR);
        serveRead(5, 1, 32'h404, 32'h5A5A5A5A);
        serveRead(0, -1, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
